// File: rtl/decoder_7_pkg.sv
// -----------------------------------------------------------------------------
// decoder_7_pkg
// Shared constants for the microwave timer seven-segment display path.
//   - SEG_0..SEG_9 : active-high patterns, bit order [6]=a .. [0]=g
//   - SEG_DASH     : shown for non-BCD codes 10..15 (segment g only)
//   - SEG_BLANK    : all segments off
//   - SEG_A..SEG_G : bit index of each segment inside a 7-bit pattern
// -----------------------------------------------------------------------------
package decoder_7_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Purely combinational BCD to seven-segment decoder for one display digit.
// Ports:
//   bcd  : in  4  BCD digit; codes 10..15 are treated as invalid
//   segs : out 7  active-high pattern, [6]=a .. [0]=g; dash for invalid codes
// -----------------------------------------------------------------------------
module seg7_digit
  import decoder_7_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] segs
);

  always_comb begin
    segs = SEG_DASH;
    case (bcd)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/decoder_7_seg.sv
// -----------------------------------------------------------------------------
// decoder_7_seg
// Registered M:SS seven-segment decoder for the microwave timer display.
// Three identical digit decoders feed one output register stage (latency 1).
// Ports:
//   clk           : in  1  rising-edge clock
//   reset         : in  1  synchronous active-high; blanks all outputs
//   sec_ones      : in  4  BCD ones-of-seconds
//   sec_tens      : in  4  BCD tens-of-seconds
//   min           : in  4  BCD minutes
//   sec_ones_segs : out 7  pattern for sec_ones ([6]=a .. [0]=g, active-high)
//   sec_tens_segs : out 7  pattern for sec_tens
//   mins_segs     : out 7  pattern for min
// Build option:
//   DECODER_7_LEADING_BLANK_EN - when defined, a zero minutes digit is blanked,
//   and a zero tens digit is blanked while minutes is also zero. The ones digit
//   is never blanked so 0:00 still shows a single "0".
// -----------------------------------------------------------------------------
module decoder_7_seg
  import decoder_7_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       sec_ones,
  input  logic [3:0]       sec_tens,
  input  logic [3:0]       min,
  output logic [SEG_W-1:0] sec_ones_segs,
  output logic [SEG_W-1:0] sec_tens_segs,
  output logic [SEG_W-1:0] mins_segs
);

  logic [SEG_W-1:0] ones_dec;
  logic [SEG_W-1:0] tens_dec;
  logic [SEG_W-1:0] mins_dec;
  logic [SEG_W-1:0] tens_shown;
  logic [SEG_W-1:0] mins_shown;

  logic [SEG_W-1:0] ones_segs_p0;
  logic [SEG_W-1:0] tens_segs_p0;
  logic [SEG_W-1:0] mins_segs_p0;

  seg7_digit u_ones (.bcd(sec_ones), .segs(ones_dec));
  seg7_digit u_tens (.bcd(sec_tens), .segs(tens_dec));
  seg7_digit u_mins (.bcd(min),      .segs(mins_dec));

`ifdef DECODER_7_LEADING_BLANK_EN
  // Only an exact zero is blanked, so invalid codes still show the dash.
  logic min_zero;
  logic tens_zero;

  always_comb begin
    min_zero   = (min == 4'd0);
    tens_zero  = (sec_tens == 4'd0);
    mins_shown = min_zero ? SEG_BLANK : mins_dec;
    tens_shown = (min_zero && tens_zero) ? SEG_BLANK : tens_dec;
  end
`else
  always_comb begin
    mins_shown = mins_dec;
    tens_shown = tens_dec;
  end
`endif

  // Stage p0: output register; reset forces a blank display.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_segs_p0 <= SEG_BLANK;
      tens_segs_p0 <= SEG_BLANK;
      mins_segs_p0 <= SEG_BLANK;
    end else begin
      ones_segs_p0 <= ones_dec;
      tens_segs_p0 <= tens_shown;
      mins_segs_p0 <= mins_shown;
    end
  end

  assign sec_ones_segs = ones_segs_p0;
  assign sec_tens_segs = tens_segs_p0;
  assign mins_segs     = mins_segs_p0;

endmodule

// File: tb/tb_decoder_7_seg.sv
// -----------------------------------------------------------------------------
// tb_decoder_7_seg
// Directed, table-driven bench for decoder_7_seg. Expected patterns are
// hand-written literals; expectations for zero leading digits follow the
// DECODER_7_LEADING_BLANK_EN build option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_7_seg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min;
  logic [6:0] sec_ones_segs;
  logic [6:0] sec_tens_segs;
  logic [6:0] mins_segs;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DECODER_7_LEADING_BLANK_EN
  localparam logic [6:0] ZERO_MIN   = 7'b0000000;
  localparam logic [6:0] ZERO_TENS0 = 7'b0000000; // tens==0 while min==0
`else
  localparam logic [6:0] ZERO_MIN   = 7'b1111110;
  localparam logic [6:0] ZERO_TENS0 = 7'b1111110;
`endif

  typedef struct {
    logic [3:0] so;
    logic [3:0] st;
    logic [3:0] mn;
    logic [6:0] exp_so;
    logic [6:0] exp_st;
    logic [6:0] exp_mn;
    string      name;
  } vec_t;

  vec_t vecs[$];

  decoder_7_seg dut (
    .clk          (clk),
    .reset        (reset),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .min          (min),
    .sec_ones_segs(sec_ones_segs),
    .sec_tens_segs(sec_tens_segs),
    .mins_segs    (mins_segs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input logic [6:0] e_so,
                        input logic [6:0] e_st, input logic [6:0] e_mn);
    check({name, ".ones"}, sec_ones_segs, e_so);
    check({name, ".tens"}, sec_tens_segs, e_st);
    check({name, ".mins"}, mins_segs,     e_mn);
  endtask

  // Drive inputs just after an edge, then sample 1 ns after the next edge.
  task automatic apply(input logic [3:0] so, input logic [3:0] st, input logic [3:0] mn);
    sec_ones = so;
    sec_tens = st;
    min      = mn;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] so, input logic [3:0] st, input logic [3:0] mn,
                     input logic [6:0] e_so, input logic [6:0] e_st, input logic [6:0] e_mn,
                     input string name);
    vec_t v;
    v.so = so; v.st = st; v.mn = mn;
    v.exp_so = e_so; v.exp_st = e_st; v.exp_mn = e_mn;
    v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    // Ones sweep at 0:0x
    add(4'd0, 4'd0, 4'd0, 7'b1111110, ZERO_TENS0, ZERO_MIN, "sweep0");
    add(4'd1, 4'd0, 4'd0, 7'b0110000, ZERO_TENS0, ZERO_MIN, "sweep1");
    add(4'd2, 4'd0, 4'd0, 7'b1101101, ZERO_TENS0, ZERO_MIN, "sweep2");
    add(4'd3, 4'd0, 4'd0, 7'b1111001, ZERO_TENS0, ZERO_MIN, "sweep3");
    add(4'd4, 4'd0, 4'd0, 7'b0110011, ZERO_TENS0, ZERO_MIN, "sweep4");
    add(4'd5, 4'd0, 4'd0, 7'b1011011, ZERO_TENS0, ZERO_MIN, "sweep5");
    add(4'd6, 4'd0, 4'd0, 7'b1011111, ZERO_TENS0, ZERO_MIN, "sweep6");
    add(4'd7, 4'd0, 4'd0, 7'b1110000, ZERO_TENS0, ZERO_MIN, "sweep7");
    add(4'd8, 4'd0, 4'd0, 7'b1111111, ZERO_TENS0, ZERO_MIN, "sweep8");
    add(4'd9, 4'd0, 4'd0, 7'b1111011, ZERO_TENS0, ZERO_MIN, "sweep9");
    // Invalid codes show a dash, never blanked
    add(4'd10, 4'd15, 4'd12, 7'b0000001, 7'b0000001, 7'b0000001, "invalid_a");
    add(4'd11, 4'd13, 4'd14, 7'b0000001, 7'b0000001, 7'b0000001, "invalid_b");
    add(4'd15, 4'd10, 4'd0,  7'b0000001, 7'b0000001, ZERO_MIN,   "invalid_min0");
    // Mixed values
    add(4'd7, 4'd4, 4'd5, 7'b1110000, 7'b0110011, 7'b1011011, "t5_47");
    add(4'd0, 4'd6, 4'd9, 7'b1111110, 7'b1011111, 7'b1111011, "t9_60");
    add(4'd3, 4'd2, 4'd8, 7'b1111001, 7'b1101101, 7'b1111111, "t8_23");
    add(4'd5, 4'd0, 4'd1, 7'b1011011, 7'b1111110, 7'b0110000, "t1_05");
    add(4'd5, 4'd3, 4'd0, 7'b1011011, 7'b1111001, ZERO_MIN,   "t0_35");
    add(4'd1, 4'd5, 4'd2, 7'b0110000, 7'b1011011, 7'b1101101, "t2_51");
    add(4'd9, 4'd1, 4'd6, 7'b1111011, 7'b0110000, 7'b1011111, "t6_19");
    add(4'd0, 4'd0, 4'd3, 7'b1111110, 7'b1111110, 7'b1111001, "t3_00");
    add(4'd5, 4'd0, 4'd0, 7'b1011011, ZERO_TENS0, ZERO_MIN,   "t0_05");

    // Reset with all inputs at 8
    reset = 1'b1;
    sec_ones = 4'd8; sec_tens = 4'd8; min = 4'd8;
    @(posedge clk); #1;
    check3("reset", 7'b0000000, 7'b0000000, 7'b0000000);
    @(posedge clk); #1;
    check3("reset_hold", 7'b0000000, 7'b0000000, 7'b0000000);
    reset = 1'b0;
    @(posedge clk); #1;
    check3("release", 7'b1111111, 7'b1111111, 7'b1111111);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].so, vecs[i].st, vecs[i].mn);
      check3(vecs[i].name, vecs[i].exp_so, vecs[i].exp_st, vecs[i].exp_mn);
    end

    // Latency: output holds the old value until the following edge
    apply(4'd7, 4'd4, 4'd5);
    sec_ones = 4'd2; sec_tens = 4'd1; min = 4'd3;
    @(negedge clk);
    check3("latency_hold", 7'b1110000, 7'b0110011, 7'b1011011);
    @(posedge clk); #1;
    check3("latency_new", 7'b1101101, 7'b0110000, 7'b1111001);

    // Glitch between edges has no effect
    sec_ones = 4'd8; #2; sec_ones = 4'd2;
    @(posedge clk); #1;
    check("glitch.ones", sec_ones_segs, 7'b1101101);

    // Reset mid-operation blanks on the next edge, then resumes
    reset = 1'b1;
    @(posedge clk); #1;
    check3("mid_reset", 7'b0000000, 7'b0000000, 7'b0000000);
    reset = 1'b0;
    sec_ones = 4'd6; sec_tens = 4'd5; min = 4'd4;
    @(posedge clk); #1;
    check3("mid_release", 7'b1011111, 7'b1011011, 7'b0110011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
